hp48_bus_sequencer: RTL and testbench

Bus master sequencer between the Saturn core and the HP48 nibble bus (I/O RAM, RAM, ROM devices). It turns one CPU transfer request (read/write 1–16 nibbles via PC or DP pointer, or a configure) into the cycle-by-cycle command stream on `bus_command`/`bus_address`. It drives the CONFIGURE daisy chain one device at a time, tracks device pointers to skip redundant LOAD commands, and reports unmapped accesses and device errors.

---
 rtl/hp48_bus_sequencer_pkg.sv | 50 +++++
 rtl/hp48_bus_sequencer_shadow.sv | 38 +++
 rtl/hp48_bus_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_hp48_bus_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hp48_bus_sequencer_pkg.sv
// Shared definitions for the HP48 nibble-bus sequencer: bus command codes,
// request encodings, sequencer states and the latched request payload.
package hp48_bus_sequencer_pkg;

   localparam int unsigned ADDR_W = 20;
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned LEN_W  = 4;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned STEP_W = 5;
   localparam int unsigned CMD_W  = 4;

   localparam logic [CMD_W-1:0] BUSCMD_NOP       = 4'h0;
   localparam logic [CMD_W-1:0] BUSCMD_ID        = 4'h1;
   localparam logic [CMD_W-1:0] BUSCMD_PC_READ   = 4'h2;
   localparam logic [CMD_W-1:0] BUSCMD_DP_READ   = 4'h3;
   localparam logic [CMD_W-1:0] BUSCMD_PC_WRITE  = 4'h4;
   localparam logic [CMD_W-1:0] BUSCMD_DP_WRITE  = 4'h5;
   localparam logic [CMD_W-1:0] BUSCMD_LOAD_PC   = 4'h6;
   localparam logic [CMD_W-1:0] BUSCMD_LOAD_DP   = 4'h7;
   localparam logic [CMD_W-1:0] BUSCMD_CONFIGURE = 4'h8;

   localparam logic [1:0] REQ_READ      = 2'b00;
   localparam logic [1:0] REQ_WRITE     = 2'b01;
   localparam logic [1:0] REQ_CONFIGURE = 2'b10;
   localparam logic [1:0] REQ_ILLEGAL   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_XFER  = 3'd2,
      ST_DONE  = 3'd3,
      ST_CFG   = 3'd4,
      ST_FAULT = 3'd5
   } seq_state_e;

   typedef struct packed {
      logic              write;
      logic              use_dp;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
      logic [DATA_W-1:0] wdata;
   } seq_req_t;

   // Transfer command for one beat, chosen by direction and pointer.
   function automatic logic [CMD_W-1:0] xfer_cmd(input logic write, input logic use_dp);
      if (write) return use_dp ? BUSCMD_DP_WRITE : BUSCMD_PC_WRITE;
      return use_dp ? BUSCMD_DP_READ : BUSCMD_PC_READ;
   endfunction

endpackage

// File: rtl/hp48_bus_sequencer_shadow.sv
// Pointer shadow: mirrors one device-side pointer (PC or DP) so that a
// transfer starting where the last one ended can skip its LOAD command.
module hp48_ptr_shadow
   import hp48_bus_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              advance,
   input  logic              invalidate,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [STEP_W-1:0] step,
   input  logic [ADDR_W-1:0] cmp_addr,
   output logic              hit_c
);

   logic [ADDR_W-1:0] value;
   logic              valid;

   // Load only records the start; the shadow becomes trustworthy once the burst completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         value <= '0;
         valid <= 1'b0;
      end else if (invalidate) begin
         valid <= 1'b0;
      end else if (load) begin
         value <= load_addr;
         valid <= 1'b0;
      end else if (advance) begin
         value <= value + ADDR_W'(step);
         valid <= 1'b1;
      end
   end

   assign hit_c = valid && (value == cmp_addr);

endmodule

// File: rtl/hp48_bus_sequencer.sv
// Saturn-side bus master: turns one CPU transfer/configure request into the
// registered per-cycle command stream of the HP48 nibble bus.
module hp48_bus_sequencer
   import hp48_bus_sequencer_pkg::*;
#(
   parameter int unsigned NUM_DEVS = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_kind,
   input  logic                req_use_dp,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [LEN_W-1:0]    req_len,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_error,
   output logic [CMD_W-1:0]    bus_command,
   output logic [ADDR_W-1:0]   bus_address,
   output logic [NIB_W-1:0]    bus_nibble_out,
   input  logic [NIB_W-1:0]    bus_nibble_in,
   input  logic [NUM_DEVS-1:0] bus_active,
   input  logic [NUM_DEVS-1:0] bus_error,
   output logic [NUM_DEVS-1:0] cfg_sel,
   output logic                all_configured,
   output logic                fault
);

   localparam int unsigned CNT_W = $clog2(NUM_DEVS + 1);

   seq_state_e        state;
   seq_req_t          req_q;
   logic [LEN_W-1:0]  beat;
   logic              err_q;
   logic [DATA_W-1:0] rd_buf;
   logic [CNT_W-1:0]  cfg_count;

   logic              fault_c, last_beat_c, err_merge_c, sel_hit_c;
   logic              pc_hit_c, dp_hit_c;
   logic              run_c, ptr_load_c, ptr_adv_c, ptr_inv_c;
   logic [LEN_W-1:0]  nxt_beat_c;
   logic [DATA_W-1:0] rd_merge_c;
   logic [STEP_W-1:0] step_c;

   // Beat bookkeeping and shadow strobes; nothing advances on a faulting edge.
   always_comb begin
      fault_c     = (state != ST_IDLE) && (|bus_error);
      run_c       = !fault_c;
      last_beat_c = (beat == req_q.len);
      nxt_beat_c  = beat + LEN_W'(1);
      err_merge_c = err_q | (bus_active == '0);
      rd_merge_c  = rd_buf;
      if (state == ST_XFER && !req_q.write)
         rd_merge_c[{beat, 2'b00} +: NIB_W] = bus_nibble_in;
      ptr_load_c  = run_c && (state == ST_LOAD);
      ptr_adv_c   = run_c && (state == ST_XFER) && last_beat_c;
      ptr_inv_c   = run_c && (state == ST_CFG) && !all_configured;
      step_c      = STEP_W'(req_q.len) + STEP_W'(1);
      sel_hit_c   = req_use_dp ? dp_hit_c : pc_hit_c;
   end

   hp48_ptr_shadow u_pc_shadow (
      .clk        (clk),
      .reset      (reset),
      .load       (ptr_load_c && !req_q.use_dp),
      .advance    (ptr_adv_c && !req_q.use_dp),
      .invalidate (ptr_inv_c),
      .load_addr  (req_q.addr),
      .step       (step_c),
      .cmp_addr   (req_addr),
      .hit_c      (pc_hit_c)
   );

   hp48_ptr_shadow u_dp_shadow (
      .clk        (clk),
      .reset      (reset),
      .load       (ptr_load_c && req_q.use_dp),
      .advance    (ptr_adv_c && req_q.use_dp),
      .invalidate (ptr_inv_c),
      .load_addr  (req_q.addr),
      .step       (step_c),
      .cmp_addr   (req_addr),
      .hit_c      (dp_hit_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         req_q          <= '0;
         beat           <= '0;
         err_q          <= 1'b0;
         rd_buf         <= '0;
         cfg_count      <= '0;
         req_ready      <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_rdata      <= '0;
         rsp_error      <= 1'b0;
         bus_command    <= BUSCMD_NOP;
         bus_address    <= '0;
         bus_nibble_out <= '0;
         cfg_sel        <= '0;
         all_configured <= 1'b0;
         fault          <= 1'b0;
      end else if (fault_c) begin
         state          <= ST_FAULT;
         fault          <= 1'b1;
         req_ready      <= 1'b0;
         rsp_valid      <= 1'b0;
         bus_command    <= BUSCMD_NOP;
         bus_address    <= '0;
         bus_nibble_out <= '0;
         cfg_sel        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  req_q     <= '{write: (req_kind == REQ_WRITE), use_dp: req_use_dp,
                                 addr: req_addr, len: req_len, wdata: req_wdata};
                  beat      <= '0;
                  err_q     <= 1'b0;
                  rd_buf    <= '0;
                  case (req_kind)
                     REQ_CONFIGURE: begin
                        state <= ST_CFG;
                        if (!all_configured) begin
                           bus_command <= BUSCMD_CONFIGURE;
                           bus_address <= req_addr;
                           cfg_sel     <= NUM_DEVS'(1) << cfg_count;
                        end
                     end
                     REQ_ILLEGAL: begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= '0;
                     end
                     default: begin
                        if (sel_hit_c) begin
                           state          <= ST_XFER;
                           bus_command    <= xfer_cmd(req_kind == REQ_WRITE, req_use_dp);
                           bus_nibble_out <= (req_kind == REQ_WRITE) ? req_wdata[NIB_W-1:0] : '0;
                        end else begin
                           state       <= ST_LOAD;
                           bus_command <= req_use_dp ? BUSCMD_LOAD_DP : BUSCMD_LOAD_PC;
                           bus_address <= req_addr;
                        end
                     end
                  endcase
               end
            end
            ST_LOAD: begin
               state          <= ST_XFER;
               bus_command    <= xfer_cmd(req_q.write, req_q.use_dp);
               bus_address    <= '0;
               bus_nibble_out <= req_q.write ? req_q.wdata[NIB_W-1:0] : '0;
            end
            // Unmapped beats only flag an error; device pointers still advance.
            ST_XFER: begin
               rd_buf <= rd_merge_c;
               err_q  <= err_merge_c;
               if (last_beat_c) begin
                  state          <= ST_DONE;
                  bus_command    <= BUSCMD_NOP;
                  bus_nibble_out <= '0;
                  rsp_valid      <= 1'b1;
                  rsp_error      <= err_merge_c;
                  rsp_rdata      <= rd_merge_c;
               end else begin
                  beat           <= nxt_beat_c;
                  bus_nibble_out <= req_q.write ? req_q.wdata[{nxt_beat_c, 2'b00} +: NIB_W] : '0;
               end
            end
            ST_CFG: begin
               state       <= ST_DONE;
               bus_command <= BUSCMD_NOP;
               bus_address <= '0;
               cfg_sel     <= '0;
               rsp_valid   <= 1'b1;
               rsp_rdata   <= '0;
               rsp_error   <= all_configured;
               if (!all_configured) begin
                  cfg_count      <= cfg_count + CNT_W'(1);
                  all_configured <= (cfg_count + CNT_W'(1)) == CNT_W'(NUM_DEVS);
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               state <= ST_FAULT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hp48_bus_sequencer.sv
// Self-checking bench: a behavioural nibble-bus device environment plus a
// request-level reference model (memory, pointer ends, configure count).
module tb_hp48_bus_sequencer;
   import hp48_bus_sequencer_pkg::*;

   localparam int unsigned ND = 3;

   logic          clk = 1'b0;
   logic          reset, req_valid, req_ready, req_use_dp;
   logic [1:0]    req_kind;
   logic [19:0]   req_addr, bus_address;
   logic [3:0]    req_len, bus_command, bus_nibble_out, bus_nibble_in;
   logic [63:0]   req_wdata, rsp_rdata;
   logic          rsp_valid, rsp_error, all_configured, fault;
   logic [ND-1:0] bus_active, bus_error, cfg_sel;

   int n_cmp = 0;
   int n_bad = 0;

   hp48_bus_sequencer #(.NUM_DEVS(ND)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_kind(req_kind), .req_use_dp(req_use_dp), .req_addr(req_addr),
      .req_len(req_len), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .bus_command(bus_command),
      .bus_address(bus_address), .bus_nibble_out(bus_nibble_out),
      .bus_nibble_in(bus_nibble_in), .bus_active(bus_active), .bus_error(bus_error),
      .cfg_sel(cfg_sel), .all_configured(all_configured), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [19:0] dev_size(input int d);
      case (d)
         0:       return 20'h1FF00;
         1:       return 20'h20000;
         default: return 20'h80000;
      endcase
   endfunction

   function automatic logic in_range(input logic [19:0] base, input int d, input logic [19:0] a);
      logic [19:0] off;
      off = a - base;
      return off < dev_size(d);
   endfunction

   // Device environment: acts on the registered command at the negedge.
   logic [19:0] dev_base [ND];
   logic        dev_on   [ND];
   logic [19:0] dev_pc, dev_dp;
   logic [3:0]  dev_mem  [logic [19:0]];

   always @(negedge clk) begin : dev_model
      logic [19:0]   a;
      logic [ND-1:0] act;
      logic          use_pc;
      bus_active    = '0;
      bus_nibble_in = '0;
      if (reset) begin
         for (int d = 0; d < ND; d++) dev_on[d] = 1'b0;
      end else begin
         case (bus_command)
            BUSCMD_LOAD_PC: dev_pc = bus_address;
            BUSCMD_LOAD_DP: dev_dp = bus_address;
            BUSCMD_CONFIGURE: begin
               for (int d = 0; d < ND; d++)
                  if (cfg_sel[d]) begin
                     dev_base[d] = bus_address;
                     dev_on[d]   = 1'b1;
                  end
            end
            BUSCMD_PC_READ, BUSCMD_DP_READ, BUSCMD_PC_WRITE, BUSCMD_DP_WRITE: begin
               use_pc = (bus_command == BUSCMD_PC_READ) || (bus_command == BUSCMD_PC_WRITE);
               a      = use_pc ? dev_pc : dev_dp;
               act    = '0;
               for (int d = 0; d < ND; d++) act[d] = dev_on[d] && in_range(dev_base[d], d, a);
               bus_active = act;
               if (act != '0) begin
                  if (bus_command == BUSCMD_PC_READ || bus_command == BUSCMD_DP_READ)
                     bus_nibble_in = dev_mem.exists(a) ? dev_mem[a] : 4'h0;
                  else
                     dev_mem[a] = bus_nibble_out;
               end
               if (use_pc) dev_pc = a + 20'd1;
               else        dev_dp = a + 20'd1;
            end
            default: ;
         endcase
      end
   end

   // Reference model: request-level view of memory, configured windows and pointer ends.
   logic [19:0] ref_base [ND];
   logic        ref_on   [ND];
   int          ref_cfg_n;
   logic [19:0] sh_a [2];
   logic        sh_v [2];
   logic [3:0]  ref_mem [logic [19:0]];

   function automatic logic ref_mapped(input logic [19:0] a);
      for (int d = 0; d < ND; d++)
         if (ref_on[d] && in_range(ref_base[d], d, a)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < ND; d++) ref_on[d] = 1'b0;
      ref_cfg_n = 0;
      sh_v[0] = 1'b0;
      sh_v[1] = 1'b0;
   endtask

   int          last_lat, last_nload;
   logic [63:0] last_rd;

   task automatic do_req(input string tag, input logic [1:0] kind, input logic dp,
                         input logic [19:0] addr, input logic [3:0] len, input logic [63:0] wd);
      logic [19:0]   a, ld_addr, cfg_addr;
      logic          hit, e_err, got;
      logic [63:0]   e_rd;
      logic [3:0]    e_ld_cmd, e_x_cmd, ld_cmd;
      logic [ND-1:0] e_sel, cfg_seen;
      int e_lat, e_load, e_beat, e_cfg, n_load, n_beat, n_cfg, n_other, lat, wait_n;
      e_err = 1'b0; e_rd = '0; e_load = 0; e_beat = 0; e_cfg = 0; e_sel = '0; e_lat = 0;
      ld_addr = '0; cfg_addr = '0; ld_cmd = '0; cfg_seen = '0;
      e_ld_cmd = dp ? BUSCMD_LOAD_DP : BUSCMD_LOAD_PC;
      if (kind == REQ_WRITE) e_x_cmd = dp ? BUSCMD_DP_WRITE : BUSCMD_PC_WRITE;
      else                   e_x_cmd = dp ? BUSCMD_DP_READ : BUSCMD_PC_READ;
      case (kind)
         REQ_ILLEGAL: begin
            e_lat = 1;
            e_err = 1'b1;
         end
         REQ_CONFIGURE: begin
            e_lat = 2;
            if (ref_cfg_n < ND) begin
               e_cfg = 1;
               e_sel = ND'(1) << ref_cfg_n;
               ref_base[ref_cfg_n] = addr;
               ref_on[ref_cfg_n]   = 1'b1;
               ref_cfg_n++;
               sh_v[0] = 1'b0;
               sh_v[1] = 1'b0;
            end else begin
               e_err = 1'b1;
            end
         end
         default: begin
            hit    = sh_v[dp] && (sh_a[dp] == addr);
            e_load = hit ? 0 : 1;
            e_beat = int'(len) + 1;
            e_lat  = e_load + e_beat + 1;
            for (int i = 0; i < e_beat; i++) begin
               a = addr + 20'(i);
               if (!ref_mapped(a)) e_err = 1'b1;
               else if (kind == REQ_WRITE) ref_mem[a] = wd[4*i +: 4];
               else e_rd[4*i +: 4] = ref_mem.exists(a) ? ref_mem[a] : 4'h0;
            end
            sh_a[dp] = addr + 20'(len) + 20'd1;
            sh_v[dp] = 1'b1;
         end
      endcase

      wait_n = 0;
      while (!req_ready && wait_n < 50) begin
         step();
         wait_n++;
      end
      check({tag, "_ready"}, 64'(req_ready), 64'd1);
      if (!req_ready) return;
      req_valid = 1'b1; req_kind = kind; req_use_dp = dp;
      req_addr = addr; req_len = len; req_wdata = wd;
      step();
      req_valid = 1'b0;

      n_load = 0; n_beat = 0; n_cfg = 0; n_other = 0; got = 1'b0; lat = 0;
      for (int k = 1; k <= 40 && !got; k++) begin
         if (rsp_valid) begin
            got = 1'b1;
            lat = k;
         end else begin
            case (bus_command)
               BUSCMD_LOAD_PC, BUSCMD_LOAD_DP: begin
                  n_load++; ld_cmd = bus_command; ld_addr = bus_address;
               end
               BUSCMD_CONFIGURE: begin
                  n_cfg++; cfg_seen = cfg_sel; cfg_addr = bus_address;
               end
               BUSCMD_NOP: ;
               default: if (bus_command == e_x_cmd) n_beat++; else n_other++;
            endcase
            step();
         end
      end
      check({tag, "_rsp"},   64'(got), 64'd1);
      check({tag, "_lat"},   64'(lat), 64'(e_lat));
      check({tag, "_err"},   64'(rsp_error), 64'(e_err));
      check({tag, "_rdata"}, rsp_rdata, e_rd);
      check({tag, "_nload"}, 64'(n_load), 64'(e_load));
      check({tag, "_nbeat"}, 64'(n_beat), 64'(e_beat));
      check({tag, "_ncfg"},  64'(n_cfg), 64'(e_cfg));
      check({tag, "_other"}, 64'(n_other), 64'd0);
      if (e_load == 1 && n_load == 1) begin
         check({tag, "_ldcmd"},  64'(ld_cmd), 64'(e_ld_cmd));
         check({tag, "_ldaddr"}, 64'(ld_addr), 64'(addr));
      end
      if (e_cfg == 1 && n_cfg == 1) begin
         check({tag, "_cfgsel"},  64'(cfg_seen), 64'(e_sel));
         check({tag, "_cfgaddr"}, 64'(cfg_addr), 64'(addr));
      end
      last_lat = lat; last_rd = rsp_rdata; last_nload = n_load;
      step();
      check({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
      check({tag, "_hold"},  rsp_rdata, e_rd);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rdata"}, rsp_rdata, 64'd0);
      check({tag, "_ctl"}, 64'({req_ready, rsp_valid, rsp_error, bus_command, bus_address,
                                 bus_nibble_out, cfg_sel, all_configured, fault}), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  kind;
      logic        dp;
      logic [19:0] addr;
      int          r, n_rsp;
      reset = 1'b1; req_valid = 1'b0; req_kind = '0; req_use_dp = 1'b0;
      req_addr = '0; req_len = '0; req_wdata = '0; bus_error = '0;
      model_reset();
      step();
      check_reset_outputs("por");
      step();
      reset = 1'b0;
      step();
      check("por_allcfg", 64'(all_configured), 64'd0);

      do_req("cfg0", REQ_CONFIGURE, 1'b0, 20'h00100, 4'd0, 64'd0);
      check("cfg0_allcfg", 64'(all_configured), 64'd0);
      do_req("cfg1", REQ_CONFIGURE, 1'b0, 20'h20000, 4'd0, 64'd0);
      do_req("cfg2", REQ_CONFIGURE, 1'b0, 20'h80000, 4'd0, 64'd0);
      check("cfg_all", 64'(all_configured), 64'd1);
      do_req("cfg3", REQ_CONFIGURE, 1'b0, 20'h40000, 4'd0, 64'd0);

      do_req("dpw", REQ_WRITE, 1'b1, 20'h00100, 4'd3, 64'h0000_0000_0000_DCBA);
      check("dpw_lat6", 64'(last_lat), 64'd6);
      do_req("pcr", REQ_READ, 1'b0, 20'h00100, 4'd3, 64'd0);
      check("pcr_dcba", 64'(last_rd[15:0]), 64'h0000_0000_0000_DCBA);
      do_req("pcr_hit", REQ_READ, 1'b0, 20'h00104, 4'd3, 64'd0);
      check("pcr_hit_lat5", 64'(last_lat), 64'd5);
      check("pcr_hit_noload", 64'(last_nload), 64'd0);

      do_req("unmap", REQ_READ, 1'b0, 20'h50000, 4'd5, 64'd0);
      do_req("wrap", REQ_READ, 1'b0, 20'hFFFF8, 4'd15, 64'd0);
      do_req("wrap_hit", REQ_READ, 1'b0, 20'h00008, 4'd0, 64'd0);
      check("wrap_hit_noload", 64'(last_nload), 64'd0);
      do_req("illegal", REQ_ILLEGAL, 1'b0, 20'h00100, 4'd0, 64'd0);

      for (int t = 0; t < 60; t++) begin
         r = $urandom_range(0, 11);
         if (r == 0)      kind = REQ_ILLEGAL;
         else if (r == 1) kind = REQ_CONFIGURE;
         else if (r < 6)  kind = REQ_WRITE;
         else             kind = REQ_READ;
         dp = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0:       addr = sh_a[dp];
            1:       addr = 20'h00100 + 20'($urandom_range(0, 255));
            2:       addr = 20'h20000 + 20'($urandom_range(0, 255));
            3:       addr = 20'h80000 + 20'($urandom_range(0, 255));
            default: addr = 20'h50000 + 20'($urandom_range(0, 255));
         endcase
         do_req($sformatf("rnd%0d", t), kind, dp, addr, 4'($urandom_range(0, 15)),
                {$urandom, $urandom});
      end

      do_req("pre", REQ_READ, 1'b0, 20'h20000, 4'd3, 64'd0);
      do_req("pre_hit", REQ_READ, 1'b0, 20'h20004, 4'd0, 64'd0);
      check("pre_hit_noload", 64'(last_nload), 64'd0);

      // Mid-burst device error: sequencer must lock up until reset.
      n_rsp = 0;
      while (!req_ready && n_rsp < 50) begin step(); n_rsp++; end
      req_valid = 1'b1; req_kind = REQ_READ; req_use_dp = 1'b1;
      req_addr = 20'h20010; req_len = 4'd7; req_wdata = '0;
      step();
      req_valid = 1'b0;
      step();
      step();
      bus_error = 3'b001;
      step();
      bus_error = '0;
      check("flt_fault", 64'(fault), 64'd1);
      check("flt_ready", 64'(req_ready), 64'd0);
      check("flt_cmd", 64'(bus_command), 64'(BUSCMD_NOP));
      n_rsp = 0;
      for (int k = 0; k < 10; k++) begin
         if (rsp_valid || req_ready || bus_command != BUSCMD_NOP) n_rsp++;
         step();
      end
      check("flt_quiet", 64'(n_rsp), 64'd0);
      check("flt_sticky", 64'(fault), 64'd1);

      reset = 1'b1;
      step();
      check_reset_outputs("rst");
      step();
      reset = 1'b0;
      model_reset();
      step();
      check("rst_allcfg", 64'(all_configured), 64'd0);
      do_req("post", REQ_READ, 1'b0, 20'h20004, 4'd0, 64'd0);
      check("post_reload", 64'(last_nload), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
